// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and sample conversion for the FFT sample buffer.
// Pure definitions: no latency, no flow control.
// Offset-binary ADC codes become two's complement by flipping the MSB.
package fft_pkg;

    localparam int FFT_LOG2_N  = 8;
    localparam int FFT_DW      = 16;
    localparam int SMP_DIV_MIN = 600;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        WAIT_RDY  = 2'd2
    } state_t;

    function automatic logic [FFT_DW-1:0] off2sgn(input logic [FFT_DW-1:0] x);
        return {~x[FFT_DW-1], x[FFT_DW-2:0]};
    endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port frame RAM: one synchronous write port, one registered read port.
// Read latency 1 cycle; write takes effect at the clock edge.
// No flow control; the caller keeps reads and writes in different banks.
module fft_dpram
    import fft_pkg::*;
#(
    parameter int AW = FFT_LOG2_N + 1,
    parameter int DW = FFT_DW
) (
    input  logic          iCLK,
    input  logic          iRESET,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_dat_d;
    logic [DW-1:0] rd_dat_q;

    always_ff @(posedge iCLK) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat_d = mem[rd_addr];
    end

    // Only the output register is reset so the array can map onto block RAM.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fft_sample_buf.sv
// Paces ADC conversions, converts samples to signed and fills ping-pong frames for the FFT.
// Sample written the cycle its ready edge arrives; read data 1 cycle after address.
// No stall: a frame finishing while the other bank is still pending is overwritten (overrun).
module fft_sample_buf
    import fft_pkg::*;
#(
    parameter int LOG2_N  = FFT_LOG2_N,
    parameter int DW      = FFT_DW,
    parameter int SMP_DIV = 1250
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    input  logic              iSTOP,
    output logic              oADC_EN,
    input  logic [DW-1:0]     iADC_DATA,
    input  logic              iADC_RDY,
    output logic              oFRAME_RDY,
    output logic              oFRAME_BANK,
    input  logic              iFRAME_ACK,
    input  logic [LOG2_N-1:0] iRD_ADDR,
    output logic [DW-1:0]     oRD_DATA,
    output logic              oBUSY,
    output logic [1:0]        oERR
);

    localparam int                DIV_W    = $clog2(SMP_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SMP_DIV - 1);
    localparam logic [LOG2_N-1:0] IDX_LAST = '1;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                rdy_q, rdy_d;
    logic                wbank_q, wbank_d;
    logic [LOG2_N-1:0]   widx_q, widx_d;
    logic                frame_rdy_q, frame_rdy_d;
    logic                frame_bank_q, frame_bank_d;
    logic [1:0]          err_q, err_d;

    logic                tick;
    logic                rdy_rise;
    logic                start_acc;
    logic                adc_en;
    logic                wr_vld;
    logic                late;
    logic                ack;
    logic                frame_done;

    assign tick      = (state_q != IDLE) && (div_q == DIV_LAST);
    assign rdy_rise  = iADC_RDY && !rdy_q;
    assign start_acc = iSTART && !iSTOP && (state_q == IDLE);

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (iSTOP) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (iSTART)   state_d = WAIT_TICK;
                WAIT_TICK: if (tick)     state_d = WAIT_RDY;
                WAIT_RDY:  if (rdy_rise) state_d = WAIT_TICK;
                default:                 state_d = IDLE;
            endcase
        end
    end

    // A tick seen while still waiting for data is the late-sample condition.
    always_comb begin
        adc_en = 1'b0;
        wr_vld = 1'b0;
        late   = 1'b0;
        if (!iSTOP) begin
            case (state_q)
                WAIT_TICK: adc_en = tick;
                WAIT_RDY: begin
                    wr_vld = rdy_rise;
                    late   = tick;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdy_d = iADC_RDY;
        if ((state_q == IDLE) || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Ack is applied before completion so a same-cycle ack frees the other bank.
    always_comb begin
        ack          = iFRAME_ACK && frame_rdy_q;
        frame_done   = wr_vld && (widx_q == IDX_LAST);
        wbank_d      = wbank_q;
        widx_d       = widx_q;
        frame_rdy_d  = frame_rdy_q && !ack;
        frame_bank_d = frame_bank_q;
        err_d        = err_q;
        if (start_acc) begin
            err_d = '0;
        end
        if (late) begin
            err_d[1] = 1'b1;
        end
        if (wr_vld) begin
            widx_d = widx_q + LOG2_N'(1);
        end
        if (frame_done) begin
            if (frame_rdy_q && !ack) begin
                err_d[0] = 1'b1;
            end else begin
                frame_rdy_d  = 1'b1;
                frame_bank_d = wbank_q;
                wbank_d      = !wbank_q;
            end
        end
        if (iSTOP) begin
            widx_d = '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            div_q        <= '0;
            rdy_q        <= 1'b0;
            wbank_q      <= 1'b0;
            widx_q       <= '0;
            frame_rdy_q  <= 1'b0;
            frame_bank_q <= 1'b0;
            err_q        <= '0;
        end else begin
            div_q        <= div_d;
            rdy_q        <= rdy_d;
            wbank_q      <= wbank_d;
            widx_q       <= widx_d;
            frame_rdy_q  <= frame_rdy_d;
            frame_bank_q <= frame_bank_d;
            err_q        <= err_d;
        end
    end

    fft_dpram #(
        .AW (LOG2_N + 1),
        .DW (DW)
    ) u_ram (
        .iCLK    (iCLK),
        .iRESET  (iRESET),
        .wr_vld  (wr_vld),
        .wr_addr ({wbank_q, widx_q}),
        .wr_dat  (off2sgn(iADC_DATA)),
        .rd_addr ({frame_bank_q, iRD_ADDR}),
        .rd_dat  (oRD_DATA)
    );

    assign oADC_EN     = adc_en;
    assign oFRAME_RDY  = frame_rdy_q;
    assign oFRAME_BANK = frame_bank_q;
    assign oBUSY       = (state_q != IDLE);
    assign oERR        = err_q;

endmodule

// File: tb/tb_fft_sample_buf.sv
// Bench for fft_sample_buf: ADC model, read scoreboard, conversion-pacing monitor.
module tb_fft_sample_buf;

    localparam int LOG2_N  = 3;
    localparam int DW      = 16;
    localparam int SMP_DIV = 600;

    logic              iCLK = 1'b0;
    logic              iRESET = 1'b0;
    logic              iSTART = 1'b0;
    logic              iSTOP = 1'b0;
    logic              oADC_EN;
    logic [DW-1:0]     iADC_DATA = '0;
    logic              iADC_RDY = 1'b0;
    logic              oFRAME_RDY;
    logic              oFRAME_BANK;
    logic              iFRAME_ACK;
    logic [LOG2_N-1:0] iRD_ADDR = '0;
    logic [DW-1:0]     oRD_DATA;
    logic              oBUSY;
    logic [1:0]        oERR;

    logic ack_main = 1'b0;
    logic ack_model = 1'b0;
    assign iFRAME_ACK = ack_main | ack_model;

    fft_sample_buf #(
        .LOG2_N  (LOG2_N),
        .DW      (DW),
        .SMP_DIV (SMP_DIV)
    ) dut (
        .iCLK        (iCLK),
        .iRESET      (iRESET),
        .iSTART      (iSTART),
        .iSTOP       (iSTOP),
        .oADC_EN     (oADC_EN),
        .iADC_DATA   (iADC_DATA),
        .iADC_RDY    (iADC_RDY),
        .oFRAME_RDY  (oFRAME_RDY),
        .oFRAME_BANK (oFRAME_BANK),
        .iFRAME_ACK  (iFRAME_ACK),
        .iRD_ADDR    (iRD_ADDR),
        .oRD_DATA    (oRD_DATA),
        .oBUSY       (oBUSY),
        .oERR        (oERR)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int k = 0;
    int late_k = -1;
    int ack_k = -1;
    int epoch = 0;
    int rdy_low_cnt = 0;
    int en_last = 0;
    int en_epoch = -1;
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    function automatic logic [15:0] adc_val(input int s);
        if (s == 38) return 16'h0000;
        if (s == 39) return 16'hFFFF;
        return 16'h8000 + 16'(s);
    endfunction

    // ADC model: answers each conversion pulse with sample k.
    initial begin : adc_model
        int dly;
        int hold;
        forever begin
            @(negedge iCLK);
            if (oADC_EN && iRESET) begin
                dly  = (k == late_k) ? 650 : 20;
                hold = (k == late_k) ? 3 : 1;
                repeat (dly) @(negedge iCLK);
                iADC_DATA = adc_val(k);
                iADC_RDY  = 1'b1;
                if (k == ack_k) ack_model = 1'b1;
                repeat (hold) @(negedge iCLK);
                iADC_RDY  = 1'b0;
                ack_model = 1'b0;
                k++;
            end
        end
    end

    always @(posedge iCLK) rd_vld <= rd_req;

    // Monitor: read-data scoreboard and conversion-pulse spacing.
    always @(negedge iCLK) begin
        cyc++;
        if (!oFRAME_RDY) rdy_low_cnt++;
        if (rd_vld) begin
            chk("rd_q_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("rd_data", oRD_DATA, exp_q.pop_front());
        end
        if (oADC_EN && iRESET) begin
            if (en_epoch == epoch)
                chk("adc_en_gap", cyc - en_last, (k - 1 == late_k) ? 2 * SMP_DIV : SMP_DIV);
            en_last  = cyc;
            en_epoch = epoch;
        end
    end

    task automatic pulse_start();
        @(negedge iCLK);
        iSTART = 1'b1;
        epoch++;
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge iCLK);
        iSTOP = 1'b1;
        @(negedge iCLK);
        iSTOP = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge iCLK);
        ack_main = 1'b1;
        @(negedge iCLK);
        ack_main = 1'b0;
    endtask

    task automatic wait_k(input int n, input string nm);
        int t = 0;
        int budget = (n - k) * 1300 + 1000;
        while (k < n && t < budget) begin
            @(negedge iCLK);
            t++;
        end
        chk(nm, k, n);
    endtask

    task automatic wait_frame(input string nm);
        int t = 0;
        while (!oFRAME_RDY && t < 8000) begin
            @(negedge iCLK);
            t++;
        end
        chk(nm, oFRAME_RDY, 1);
    endtask

    task automatic read_bank(input logic [15:0] v [8]);
        for (int i = 0; i < 8; i++) begin
            @(negedge iCLK);
            iRD_ADDR = LOG2_N'(i);
            rd_req   = 1'b1;
            exp_q.push_back(v[i]);
        end
        @(negedge iCLK);
        rd_req = 1'b0;
        @(negedge iCLK);
    endtask

    initial begin : main
        logic [15:0] ev [8];
        int low0;

        repeat (3) @(negedge iCLK);
        chk("rst_adc_en", oADC_EN, 0);
        chk("rst_frame_rdy", oFRAME_RDY, 0);
        chk("rst_frame_bank", oFRAME_BANK, 0);
        chk("rst_busy", oBUSY, 0);
        chk("rst_err", oERR, 0);
        chk("rst_rd_data", oRD_DATA, 0);
        iRESET = 1'b1;
        @(negedge iCLK);

        // Single frame into bank 0.
        pulse_start();
        chk("t1_busy", oBUSY, 1);
        wait_frame("t1_frame_rdy");
        chk("t1_bank", oFRAME_BANK, 0);
        chk("t1_err", oERR, 0);
        for (int i = 0; i < 8; i++) ev[i] = 16'(i);
        read_bank(ev);

        // Ping-pong: ack frame 0 while frame 1 fills bank 1.
        pulse_ack();
        chk("t2_rdy_clear", oFRAME_RDY, 0);
        wait_frame("t2_frame_rdy");
        chk("t2_bank", oFRAME_BANK, 1);
        chk("t2_err", oERR, 0);
        for (int i = 0; i < 8; i++) ev[i] = 16'h0008 + 16'(i);
        read_bank(ev);

        // Overrun: frame of samples 16..23 completes while bank 1 still pending.
        wait_k(23, "t3_k_pre");
        chk("t3_err_pre", oERR, 0);
        wait_k(24, "t3_k_post");
        chk("t3_err_overrun", oERR, 1);
        chk("t3_bank_kept", oFRAME_BANK, 1);
        chk("t3_rdy_kept", oFRAME_RDY, 1);
        pulse_ack();
        chk("t3_rdy_clear", oFRAME_RDY, 0);
        wait_frame("t3_frame_rdy");
        chk("t3_bank_new", oFRAME_BANK, 0);
        for (int i = 0; i < 8; i++) ev[i] = 16'h0018 + 16'(i);
        read_bank(ev);

        // Stop after 5 samples of the next frame.
        wait_k(37, "t6_k_stop");
        pulse_stop();
        chk("t6_busy_stop", oBUSY, 0);
        chk("t6_rdy_kept", oFRAME_RDY, 1);
        chk("t6_bank_kept", oFRAME_BANK, 0);
        repeat (SMP_DIV + 100) @(negedge iCLK);
        chk("t6_no_conv", k, 37);

        // Restart refills from addr 0; ack lands on the completing write.
        ack_k = 44;
        pulse_start();
        chk("t4_err_cleared", oERR, 0);
        chk("t4_busy", oBUSY, 1);
        wait_k(44, "t4_k_pre");
        low0 = rdy_low_cnt;
        chk("t4_bank_pre", oFRAME_BANK, 0);
        wait_k(45, "t4_k_post");
        chk("t4_rdy_never_low", rdy_low_cnt - low0, 0);
        chk("t4_rdy", oFRAME_RDY, 1);
        chk("t4_bank_swap", oFRAME_BANK, 1);
        chk("t4_err", oERR, 0);
        ev[0] = 16'h0025; ev[1] = 16'h8000; ev[2] = 16'h7FFF; ev[3] = 16'h0028;
        ev[4] = 16'h0029; ev[5] = 16'h002A; ev[6] = 16'h002B; ev[7] = 16'h002C;
        read_bank(ev);

        // Late sample with level ready held 3 cycles.
        late_k = 45;
        pulse_ack();
        chk("t5_rdy_clear", oFRAME_RDY, 0);
        wait_k(46, "t5_k_late");
        chk("t5_err_late", oERR, 2);
        wait_frame("t5_frame_rdy");
        chk("t5_bank", oFRAME_BANK, 0);
        chk("t5_err_kept", oERR, 2);
        for (int i = 0; i < 8; i++) ev[i] = 16'h002D + 16'(i);
        read_bank(ev);

        // Asynchronous reset mid-frame.
        wait_k(55, "t6_k_mid");
        repeat (50) @(negedge iCLK);
        @(posedge iCLK);
        #3 iRESET = 1'b0;
        #1;
        chk("arst_adc_en", oADC_EN, 0);
        chk("arst_frame_rdy", oFRAME_RDY, 0);
        chk("arst_frame_bank", oFRAME_BANK, 0);
        chk("arst_busy", oBUSY, 0);
        chk("arst_err", oERR, 0);
        chk("arst_rd_data", oRD_DATA, 0);
        repeat (5) @(negedge iCLK);
        chk("rd_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
